// File: rtl/crossbar_mac_if.sv
// crossbar_mac_if: command, result and status bundle between host logic and the crossbar array
interface crossbar_mac_if #(
    parameter int ROWS = 8,
    parameter int COLS = 8
);
    localparam int SUM_W = $clog2(ROWS + 1);
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [1:0]             cmd_op;
    logic [ROWS-1:0]        cmd_rows;
    logic [COLS-1:0]        cmd_cols;
    logic                   res_valid;
    logic                   res_ready;
    logic [COLS*SUM_W-1:0]  res_sum;
    logic [COLS-1:0]        res_bits;
    logic                   prog_done;
    logic                   prog_err;
    logic                   busy;
    modport master (
        output cmd_valid, cmd_op, cmd_rows, cmd_cols, res_ready,
        input  cmd_ready, res_valid, res_sum, res_bits, prog_done, prog_err, busy
    );
    modport slave (
        input  cmd_valid, cmd_op, cmd_rows, cmd_cols, res_ready,
        output cmd_ready, res_valid, res_sum, res_bits, prog_done, prog_err, busy
    );
endinterface

// File: rtl/crossbar_mac_array.sv
// crossbar_mac_array: behavioural ReRAM crossbar with FORM/SET/RESET programming and a row-serial binary MAC
module crossbar_mac_array #(
    parameter int ROWS        = 8,
    parameter int COLS        = 8,
    parameter int PROG_CYCLES = 4,
    parameter int THRESH      = 4
) (
    input logic           clk,
    input logic           rst,
    crossbar_mac_if.slave bus
);
    localparam int SUM_W   = $clog2(ROWS + 1);
    localparam int RW      = $clog2(ROWS);
    localparam int CNT_MAX = (PROG_CYCLES > ROWS) ? PROG_CYCLES : ROWS;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [SUM_W-1:0] TH = SUM_W'(THRESH);
    localparam logic [1:0] OP_FORM = 2'd0;
    localparam logic [1:0] OP_SET  = 2'd1;
    localparam logic [1:0] OP_MAC  = 2'd3;

    typedef enum logic [1:0] {IDLE, PROG, MAC, RESP} state_t;

    state_t                       state_q;
    logic [1:0]                   op_q;
    logic [ROWS-1:0]              rows_q;
    logic [COLS-1:0]              cols_q;
    logic [CW-1:0]                cnt_q;
    logic [ROWS-1:0][COLS-1:0]    cell_q, cell_d, formed_q, formed_d;
    logic                         err_d;
    logic [COLS-1:0][SUM_W-1:0]   acc_q, acc_d, res_sum_q;
    logic [COLS-1:0]              res_bits_q, bits_d;
    logic                         prog_done_q, prog_err_q;
    logic [RW-1:0]                row;

    assign row = cnt_q[RW-1:0];

    // Array contents after committing the latched program command; SET/RESET only touch formed cells
    always_comb begin
        cell_d   = cell_q;
        formed_d = formed_q;
        err_d    = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (rows_q[r] && cols_q[c]) begin
                    if (op_q == OP_FORM) begin
                        formed_d[r][c] = 1'b1;
                        cell_d[r][c]   = 1'b1;
                    end else if (!formed_q[r][c]) begin
                        err_d = 1'b1;
                    end else begin
                        cell_d[r][c] = (op_q == OP_SET);
                    end
                end
            end
        end
    end

    // Column accumulators including the current row, and their thresholded bits
    always_comb begin
        acc_d  = acc_q;
        bits_d = '0;
        for (int j = 0; j < COLS; j++) begin
            acc_d[j]  = acc_q[j] + SUM_W'(rows_q[row] & cell_q[row][j] & formed_q[row][j]);
            bits_d[j] = (acc_d[j] >= TH);
        end
    end

    // Command FSM: accept in IDLE, time the program pulse, walk rows for MAC, hold result until taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= '0;
            rows_q      <= '0;
            cols_q      <= '0;
            cnt_q       <= '0;
            cell_q      <= '0;
            formed_q    <= '0;
            acc_q       <= '0;
            res_sum_q   <= '0;
            res_bits_q  <= '0;
            prog_done_q <= 1'b0;
            prog_err_q  <= 1'b0;
        end else begin
            prog_done_q <= 1'b0;
            prog_err_q  <= 1'b0;
            case (state_q)
                IDLE: if (bus.cmd_valid) begin
                    op_q    <= bus.cmd_op;
                    rows_q  <= bus.cmd_rows;
                    cols_q  <= bus.cmd_cols;
                    cnt_q   <= '0;
                    acc_q   <= '0;
                    state_q <= (bus.cmd_op == OP_MAC) ? MAC : PROG;
                end
                PROG: if (cnt_q == CW'(PROG_CYCLES - 1)) begin
                    cell_q      <= cell_d;
                    formed_q    <= formed_d;
                    prog_done_q <= 1'b1;
                    prog_err_q  <= err_d;
                    state_q     <= IDLE;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                MAC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(ROWS - 1)) begin
                        res_sum_q  <= acc_d;
                        res_bits_q <= bits_d;
                        state_q    <= RESP;
                    end
                end
                RESP: if (bus.res_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.res_valid = (state_q == RESP);
    assign bus.res_sum   = res_sum_q;
    assign bus.res_bits  = res_bits_q;
    assign bus.prog_done = prog_done_q;
    assign bus.prog_err  = prog_err_q;
endmodule

// File: tb/tb_crossbar_mac_array.sv
// tb_crossbar_mac_array: directed scenario tests for the crossbar MAC array
module tb_crossbar_mac_array;
    localparam int ROWS = 8;
    localparam int COLS = 8;
    localparam logic [1:0] FORM = 2'd0, SET = 2'd1, RST_OP = 2'd2, MACOP = 2'd3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   err_seen = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (bus.prog_err) err_seen = 1;

    crossbar_mac_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

    crossbar_mac_array #(.ROWS(ROWS), .COLS(COLS), .PROG_CYCLES(4), .THRESH(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic issue(input logic [1:0] op, input logic [7:0] rows, input logic [7:0] cols, output bit ok);
        ok = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_rows  = rows;
        bus.cmd_cols  = cols;
        for (int k = 0; k < 50; k++) begin
            if (bus.cmd_ready) begin
                @(posedge clk); #1;
                ok = 1;
                break;
            end
            @(posedge clk); #1;
        end
        bus.cmd_valid = 1'b0;
    endtask

    task automatic prog(input logic [1:0] op, input logic [7:0] rows, input logic [7:0] cols, output int lat, output logic err);
        bit ok;
        lat = -1;
        err = 1'bx;
        issue(op, rows, cols, ok);
        if (!ok) return;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (bus.prog_done) begin
                lat = k;
                err = bus.prog_err;
                break;
            end
        end
    endtask

    task automatic mac_run(input logic [7:0] rows, output int lat);
        bit ok;
        lat = -1;
        issue(MACOP, rows, 8'h00, ok);
        if (!ok) return;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            if (bus.res_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic take();
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", bus.cmd_ready); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        total++; if (bus.res_valid !== 1'b0) begin bad++; $display("FAIL reset_res_valid got=%b exp=0", bus.res_valid); end
        total++; if (bus.res_sum !== 32'h0) begin bad++; $display("FAIL reset_sum got=%h exp=0", bus.res_sum); end
        total++; if (bus.res_bits !== 8'h00) begin bad++; $display("FAIL reset_bits got=%h exp=00", bus.res_bits); end
        total++; if (bus.prog_done !== 1'b0) begin bad++; $display("FAIL reset_prog_done got=%b exp=0", bus.prog_done); end
    endtask

    task automatic test_mac_unprogrammed();
        int lat;
        err_seen = 0;
        mac_run(8'hFF, lat);
        total++; if (lat !== 8) begin bad++; $display("FAIL t1_latency got=%0d exp=8", lat); end
        total++; if (bus.res_sum !== 32'h0) begin bad++; $display("FAIL t1_sum got=%h exp=0", bus.res_sum); end
        total++; if (bus.res_bits !== 8'h00) begin bad++; $display("FAIL t1_bits got=%h exp=00", bus.res_bits); end
        take();
        total++; if (err_seen !== 1'b0) begin bad++; $display("FAIL t1_prog_err got=%b exp=0", err_seen); end
    endtask

    task automatic test_set_unformed();
        int lat;
        logic err;
        prog(SET, 8'h01, 8'hFF, lat, err);
        total++; if (lat !== 4) begin bad++; $display("FAIL t2_prog_latency got=%0d exp=4", lat); end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL t2_prog_err got=%b exp=1", err); end
        @(posedge clk); #1;
        total++; if (bus.prog_done !== 1'b0) begin bad++; $display("FAIL t2_done_pulse got=%b exp=0", bus.prog_done); end
        mac_run(8'h01, lat);
        total++; if (bus.res_sum !== 32'h0) begin bad++; $display("FAIL t2_sum got=%h exp=0", bus.res_sum); end
        take();
    endtask

    task automatic test_form_reset_mac();
        int lat;
        logic err;
        prog(FORM, 8'hFF, 8'hFF, lat, err);
        total++; if (lat !== 4 || err !== 1'b0) begin bad++; $display("FAIL t3_form got lat=%0d err=%b exp lat=4 err=0", lat, err); end
        prog(RST_OP, 8'hF0, 8'hFF, lat, err);
        total++; if (lat !== 4 || err !== 1'b0) begin bad++; $display("FAIL t3_reset got lat=%0d err=%b exp lat=4 err=0", lat, err); end
        mac_run(8'hFF, lat);
        total++; if (lat !== 8) begin bad++; $display("FAIL t3_latency got=%0d exp=8", lat); end
        total++; if (bus.res_sum !== 32'h4444_4444 || bus.res_bits !== 8'hFF) begin bad++; $display("FAIL t3_mac_ff got sum=%h bits=%h exp sum=44444444 bits=ff", bus.res_sum, bus.res_bits); end
        take();
        mac_run(8'h0F, lat);
        total++; if (bus.res_sum !== 32'h4444_4444 || bus.res_bits !== 8'hFF) begin bad++; $display("FAIL t3_mac_0f got sum=%h bits=%h exp sum=44444444 bits=ff", bus.res_sum, bus.res_bits); end
        take();
        mac_run(8'h0E, lat);
        total++; if (bus.res_sum !== 32'h3333_3333 || bus.res_bits !== 8'h00) begin bad++; $display("FAIL t3_mac_0e got sum=%h bits=%h exp sum=33333333 bits=00", bus.res_sum, bus.res_bits); end
        take();
        mac_run(8'hF0, lat);
        total++; if (bus.res_sum !== 32'h0 || bus.res_bits !== 8'h00) begin bad++; $display("FAIL t3_mac_f0 got sum=%h bits=%h exp sum=0 bits=00", bus.res_sum, bus.res_bits); end
        take();
        prog(SET, 8'hF0, 8'h0F, lat, err);
        total++; if (lat !== 4 || err !== 1'b0) begin bad++; $display("FAIL t3_set got lat=%0d err=%b exp lat=4 err=0", lat, err); end
        mac_run(8'hFF, lat);
        total++; if (bus.res_sum !== 32'h4444_8888 || bus.res_bits !== 8'hFF) begin bad++; $display("FAIL t3_mac_set got sum=%h bits=%h exp sum=44448888 bits=ff", bus.res_sum, bus.res_bits); end
        take();
        prog(FORM, 8'h00, 8'hFF, lat, err);
        total++; if (lat !== 4 || err !== 1'b0) begin bad++; $display("FAIL t3_empty_mask got lat=%0d err=%b exp lat=4 err=0", lat, err); end
    endtask

    task automatic test_hold();
        int lat;
        int unstable = 0;
        mac_run(8'hF1, lat);
        total++; if (bus.res_sum !== 32'h1111_5555 || bus.res_bits !== 8'h0F) begin bad++; $display("FAIL t4_result got sum=%h bits=%h exp sum=11115555 bits=0f", bus.res_sum, bus.res_bits); end
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (bus.res_valid !== 1'b1 || bus.cmd_ready !== 1'b0 || bus.res_sum !== 32'h1111_5555 || bus.res_bits !== 8'h0F) unstable++;
        end
        total++; if (unstable !== 0) begin bad++; $display("FAIL t4_hold got unstable_cycles=%0d exp=0", unstable); end
        take();
        total++; if (bus.res_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL t4_release got valid=%b ready=%b exp valid=0 ready=1", bus.res_valid, bus.cmd_ready); end
        total++; if (bus.res_sum !== 32'h1111_5555) begin bad++; $display("FAIL t4_sum_after got=%h exp=11115555", bus.res_sum); end
    endtask

    task automatic test_reset_mid_prog();
        bit ok;
        int lat;
        int done_seen = 0;
        issue(FORM, 8'h08, 8'hFF, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL t5_accept got=%b exp=1", ok); end
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            if (bus.prog_done) done_seen++;
        end
        rst = 1'b0;
        total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL t5_ready got=%b exp=1", bus.cmd_ready); end
        repeat (6) begin
            @(posedge clk); #1;
            if (bus.prog_done) done_seen++;
        end
        total++; if (done_seen !== 0) begin bad++; $display("FAIL t5_no_done got=%0d exp=0", done_seen); end
        mac_run(8'hFF, lat);
        total++; if (bus.res_sum !== 32'h0 || bus.res_bits !== 8'h00) begin bad++; $display("FAIL t5_array got sum=%h bits=%h exp sum=0 bits=00", bus.res_sum, bus.res_bits); end
        take();
    endtask

    task automatic test_back_to_back();
        int t1 = -1;
        int t2 = -1;
        int lat = -1;
        logic r;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = FORM;
        bus.cmd_rows  = 8'h05;
        bus.cmd_cols  = 8'hFF;
        for (int k = 0; k < 20; k++) begin
            r = bus.cmd_ready;
            @(posedge clk); #1;
            if (r) begin t1 = cyc; break; end
        end
        bus.cmd_op   = MACOP;
        bus.cmd_rows = 8'h07;
        for (int k = 0; k < 20; k++) begin
            r = bus.cmd_ready;
            @(posedge clk); #1;
            if (r) begin t2 = cyc; break; end
        end
        bus.cmd_valid = 1'b0;
        total++; if (t1 < 0 || t2 - t1 !== 5) begin bad++; $display("FAIL t6_gap got=%0d exp=5", t2 - t1); end
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            if (bus.res_valid) begin lat = k; break; end
        end
        total++; if (lat !== 8) begin bad++; $display("FAIL t6_latency got=%0d exp=8", lat); end
        total++; if (bus.res_sum !== 32'h2222_2222 || bus.res_bits !== 8'h00) begin bad++; $display("FAIL t6_sum got sum=%h bits=%h exp sum=22222222 bits=00", bus.res_sum, bus.res_bits); end
        take();
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'd0;
        bus.cmd_rows  = '0;
        bus.cmd_cols  = '0;
        bus.res_ready = 1'b0;
        test_reset();
        test_mac_unprogrammed();
        test_set_unformed();
        test_form_reset_mac();
        test_hold();
        test_reset_mid_prog();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
